// File: rtl/hififo_pkg.sv
// Shared definitions for the hififo PIO block: word addresses of the PIO
// registers (also used by pcie_tx and the channel FIFOs) and the encoding
// of the interrupt request state machine.
package hififo_pkg;

  // PIO register word addresses
  localparam int unsigned HIFIFO_REG_ID      = 0;
  localparam int unsigned HIFIFO_REG_ENABLE  = 1;
  localparam int unsigned HIFIFO_REG_PENDING = 2;
  localparam int unsigned HIFIFO_REG_HOLDOFF = 3;

  // Width of the interrupt coalescing holdoff register, in clock cycles
  localparam int unsigned HIFIFO_HOLDOFF_W = 16;

  // Interrupt request state machine encoding
  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ASSERT  = 2'd1,
    IRQ_HOLDOFF = 2'd2
  } irq_state_t;

endpackage

// File: rtl/hififo_irq_fsm.sv
// Interrupt request sequencer for the hififo core.
// Raises interrupt_out when fire is seen in IDLE, holds it until the core
// samples interrupt_rdy, then (when HIFIFO_IRQ_COALESCE_EN is defined) waits
// out a holdoff period before it may raise the next request. A raised
// request is never withdrawn, whatever fire does meanwhile.
// Optional feature macro: HIFIFO_IRQ_COALESCE_EN.
module hififo_irq_fsm
  import hififo_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        fire,
  input  logic                        interrupt_rdy,
  input  logic [HIFIFO_HOLDOFF_W-1:0] holdoff,
  output logic                        interrupt_out
);

  irq_state_t state;
  irq_state_t state_next;

`ifdef HIFIFO_IRQ_COALESCE_EN
  logic [HIFIFO_HOLDOFF_W-1:0] cnt;
  logic [HIFIFO_HOLDOFF_W-1:0] cnt_next;

  // Holdoff counter register; loaded on acknowledge, frozen against later
  // holdoff register writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end
`else
  // Holdoff is not used when coalescing is compiled out.
  logic unused_holdoff;
  assign unused_holdoff = ^holdoff;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IRQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. HOLDOFF lasts exactly holdoff cycles, so the spacing
  // from acknowledge to the next request is holdoff+2 cycles; a zero holdoff
  // skips HOLDOFF entirely and matches the non-coalescing timing.
  always_comb begin
    state_next = state;
`ifdef HIFIFO_IRQ_COALESCE_EN
    cnt_next   = cnt;
`endif
    case (state)
      IRQ_IDLE: begin
        if (fire) begin
          state_next = IRQ_ASSERT;
        end
      end
      IRQ_ASSERT: begin
        if (interrupt_rdy) begin
`ifdef HIFIFO_IRQ_COALESCE_EN
          if (holdoff == '0) begin
            state_next = IRQ_IDLE;
          end else begin
            state_next = IRQ_HOLDOFF;
            cnt_next   = holdoff;
          end
`else
          state_next = IRQ_IDLE;
`endif
        end
      end
`ifdef HIFIFO_IRQ_COALESCE_EN
      IRQ_HOLDOFF: begin
        cnt_next = cnt - 16'd1;
        if (cnt <= 16'd1) begin
          state_next = IRQ_IDLE;
        end
      end
`endif
      default: begin
        state_next = IRQ_IDLE;
      end
    endcase
  end

  assign interrupt_out = (state == IRQ_ASSERT);

endmodule

// File: rtl/hififo_pio_ctrl.sv
// PIO register file and interrupt controller for the hififo PCIe core.
// Decodes PIO reads/writes from pcie_rx, keeps per-channel pending/enable
// interrupt state plus a software interrupt bit, returns read completions
// to pcie_tx one cycle after the read strobe, and drives the core interrupt
// request through hififo_irq_fsm.
// Optional feature macro: HIFIFO_IRQ_COALESCE_EN (holdoff register 3).
module hififo_pio_ctrl
  import hififo_pkg::*;
#(
  parameter int          NCH      = 4,
  parameter int          ADDR_W   = 13,
  parameter logic [63:0] ID_VALUE = 64'd257
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [63:0]       wdata,
  input  logic [NCH-1:0]    ch_irq,
  input  logic              interrupt_rdy,
  output logic              interrupt_out,
  output logic              rc_done,
  output logic [63:0]       rc_data
);

  logic                        sel_id;
  logic                        sel_enable;
  logic                        sel_pending;
  logic                        sel_holdoff;
  logic [NCH-1:0]              enable;
  logic [NCH-1:0]              pending;
  logic [NCH-1:0]              pending_next;
  logic [NCH-1:0]              pending_clr;
  logic                        sw;
  logic [HIFIFO_HOLDOFF_W-1:0] holdoff;
  logic [63:0]                 rd_mux;
  logic                        fire;
  logic                        unused_wdata;

  // Only the low bits of wdata land in registers.
  assign unused_wdata = ^wdata;

  assign sel_id      = (address == ADDR_W'(HIFIFO_REG_ID));
  assign sel_enable  = (address == ADDR_W'(HIFIFO_REG_ENABLE));
  assign sel_pending = (address == ADDR_W'(HIFIFO_REG_PENDING));
  assign sel_holdoff = (address == ADDR_W'(HIFIFO_REG_HOLDOFF));

  // Channel interrupt enable register
  always_ff @(posedge clock) begin
    if (reset) begin
      enable <= '0;
    end else if (wr_valid && sel_enable) begin
      enable <= wdata[NCH-1:0];
    end
  end

  // Pending update: W1C first, then new events, so a channel event arriving
  // in the same cycle as its clear keeps the bit set.
  always_comb begin
    pending_clr  = '0;
    if (wr_valid && sel_pending) begin
      pending_clr = wdata[NCH-1:0];
    end
    pending_next = (pending & ~pending_clr) | ch_irq;
  end

  // Channel pending register
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Software interrupt bit: set via the ID address, cleared via W1C bit NCH
  always_ff @(posedge clock) begin
    if (reset) begin
      sw <= 1'b0;
    end else if (wr_valid && sel_id && wdata[0]) begin
      sw <= 1'b1;
    end else if (wr_valid && sel_pending && wdata[NCH]) begin
      sw <= 1'b0;
    end
  end

`ifdef HIFIFO_IRQ_COALESCE_EN
  // Coalescing holdoff register, in clock cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      holdoff <= '0;
    end else if (wr_valid && sel_holdoff) begin
      holdoff <= wdata[HIFIFO_HOLDOFF_W-1:0];
    end
  end
`else
  assign holdoff = '0;
`endif

  // Read mux over current register contents (pre-write on a same-cycle write)
  always_comb begin
    rd_mux = '0;
    if (sel_id) begin
      rd_mux = ID_VALUE;
    end else if (sel_enable) begin
      rd_mux = 64'(enable);
    end else if (sel_pending) begin
      rd_mux = 64'({sw, pending});
    end else if (sel_holdoff) begin
      rd_mux = 64'(holdoff);
    end
  end

  // Read completion: one-cycle pulse, payload held until the next read
  always_ff @(posedge clock) begin
    if (reset) begin
      rc_done <= 1'b0;
      rc_data <= '0;
    end else begin
      rc_done <= rd_valid;
      if (rd_valid) begin
        rc_data <= rd_mux;
      end
    end
  end

  assign fire = sw | (|(pending & enable));

  hififo_irq_fsm u_irq_fsm (
    .clock         (clock),
    .reset         (reset),
    .fire          (fire),
    .interrupt_rdy (interrupt_rdy),
    .holdoff       (holdoff),
    .interrupt_out (interrupt_out)
  );

endmodule

// File: doc/hififo_pio_ctrl.md
# hififo_pio_ctrl

Parametrised PIO register and interrupt controller for the hififo PCIe core, replacing the fixed single-bit interrupt and constant-ID readback in the top level. It sits between `pcie_rx`/`pcie_tx` and the per-channel FIFO blocks. It decodes PIO writes and reads, keeps per-channel interrupt pending/enable state for `NCH` channels, and returns read-completion data to `pcie_tx`. It also drives the core interrupt request with a ready handshake and optional coalescing holdoff.

## Interface
- `NCH`, 4: number of FIFO channels raising interrupts, 1..16
- `ADDR_W`, 13: PIO address width, in 64-bit word units
- `ID_VALUE`, 64'd257: value returned by a read of address 0
- `clock` in 1: PCIe user clock; all logic on rising edge
- `reset` in 1: synchronous, active-high; clears all state
- `wr_valid` in 1: PIO write strobe from `pcie_rx`, one cycle per write
- `rd_valid` in 1: PIO read strobe from `pcie_rx`, one cycle per read
- `address` in `ADDR_W`: PIO word address, qualified by `wr_valid`/`rd_valid`
- `wdata` in 64: PIO write data
- `ch_irq` in `NCH`: one-cycle event pulses from channel FIFOs
- `interrupt_rdy` in 1: core accepts interrupt request
- `interrupt_out` out 1: interrupt request to core
- `rc_done` out 1: read-completion data valid pulse to `pcie_tx`
- `rc_data` out 64: read-completion payload

## Operation
Register map (word addresses):
- 0: read `ID_VALUE`. Write with `wdata[0]=1` sets software pending bit `sw`.
- 1: `enable[NCH-1:0]`, R/W. Reset 0.
- 2: read `{sw, pending[NCH-1:0]}`, zero-extended. Write is write-1-to-clear (W1C) on the same bit positions.
- 3: `holdoff[15:0]`, R/W, in clock cycles. Reset 0.
- All other addresses: read 0, writes ignored.

Pending bits:
- `pending[i]` sets on `ch_irq[i]`, regardless of enable.
- On the same cycle as a W1C of that bit, set wins: bit stays 1.
- `sw` is always enabled.
- `fire = sw | |(pending & enable)`.

Interrupt FSM, states IDLE, ASSERT, HOLDOFF:
- IDLE: if `fire`, go to ASSERT; `interrupt_out` goes to 1 the next cycle.
- ASSERT: hold `interrupt_out=1` until `interrupt_rdy` is sampled 1. Then `interrupt_out=0`, load `cnt<=holdoff`, go to HOLDOFF.
- ASSERT ignores `fire` changes: a request, once raised, is never withdrawn.
- HOLDOFF: `cnt` decrements each cycle; when `cnt==0`, go to IDLE.
- `holdoff` writes during HOLDOFF do not affect the running count.
- Interrupts are level-based. If `fire` is still true on return to IDLE, a new request is raised.

Reads and writes:
- Reads return register contents as of the cycle `rd_valid` is sampled.
- A write and a read strobed in the same cycle: the read returns the pre-write value.

## Timing
- Reset values: `interrupt_out=0`, `rc_done=0`, `rc_data=0`, FSM state IDLE, all registers 0.
- Read latency: `rd_valid` at cycle N gives `rc_done=1` and valid `rc_data` at N+1. `rc_done` is high for exactly one cycle. `rc_data` holds its value until the next read.
- Back-to-back reads on consecutive cycles give back-to-back `rc_done` pulses; there is no backpressure.
- Write latency: a register write at N is visible from N+1. A W1C at N makes `pending` clear at N+1.
- Minimum interrupt spacing: `holdoff+2` cycles from `interrupt_rdy` to the next `interrupt_out` rise.
- `interrupt_rdy` while not in ASSERT is ignored.
- Reset in ASSERT or HOLDOFF: `interrupt_out` drops at the next edge and the FSM returns to IDLE. A read in flight gets no `rc_done`.

## Configuration
- `HIFIFO_IRQ_COALESCE_EN` defined: the holdoff register and HOLDOFF state exist as described.
- Undefined: register 3 reads 0 and writes are ignored. ASSERT goes directly to IDLE after `interrupt_rdy`, so minimum spacing is 2 cycles.

## Structure
- Shared package `hififo_pkg` holds the register address constants (`HIFIFO_REG_ID`, `HIFIFO_REG_ENABLE`, `HIFIFO_REG_PENDING`, `HIFIFO_REG_HOLDOFF`) and the FSM state encoding. `pcie_tx` and the channel FIFOs reuse the same address constants.
- One sub-module, `hififo_irq_fsm`, contains the IDLE/ASSERT/HOLDOFF FSM and the holdoff counter. Inputs: `fire`, `interrupt_rdy`, `holdoff`. Output: `interrupt_out`.
- Register decode and the read mux stay in the top of `hififo_pio_ctrl`.

## Test plan
- ID and reset: release reset, read addr 0 → `rc_done` one cycle later with `rc_data=257`. Read addr 7 → `rc_data=0`.
- Masking: `NCH=4`, pulse `ch_irq[2]` with enable=0 → no interrupt; addr 2 reads 0x4. Write enable=0x4 → `interrupt_out` high two cycles later. Hold `interrupt_rdy` low 5 cycles → `interrupt_out` stays high; assert `interrupt_rdy` → it drops next cycle.
- W1C race: `ch_irq[1]` pulse in the same cycle as a W1C of 0x2 → addr 2 still reads 0x2. A second W1C alone → reads 0.
- Coalescing (macro on): holdoff=100, pending bit left set → consecutive `interrupt_out` rises are exactly 102 cycles apart after `interrupt_rdy`. Macro off → 2 cycles apart, and addr 3 reads 0.
- Software interrupt: write addr 0 `wdata=1` with enable=0 → `interrupt_out` rises. W1C bit `NCH` (0x10) → no further requests.
- Reset mid-ASSERT: assert `reset` while `interrupt_out=1` → `interrupt_out=0` next edge, all registers read 0 after release.
